// File: rtl/arcade_input_dsw.sv
// rtl/arcade_input_dsw.sv - DIP-switch capture, joystick-to-player-byte mapping and coin pulse shaping
module arcade_input_dsw #(
    parameter int         NUM_PLAYERS = 2,
    parameter int         NUM_DSW     = 8,
    parameter logic [7:0] DSW_INDEX   = 8'd254,
    parameter int         COIN_BIT    = 8,
    parameter int         START_BIT   = 9,
    parameter logic [3:0] COIN_FRAMES = 4'd3
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     ioctl_download,
    input  logic                     ioctl_wr,
    input  logic [7:0]               ioctl_index,
    input  logic [26:0]              ioctl_addr,
    input  logic [15:0]              ioctl_dout,
    input  logic                     vblank,
    input  logic [16*NUM_PLAYERS-1:0] joy,
    output logic [8*NUM_DSW-1:0]     dsw,
    output logic                     dsw_valid,
    output logic [8*NUM_PLAYERS-1:0] player,
    output logic [NUM_PLAYERS-1:0]   coin,
    output logic [NUM_PLAYERS-1:0]   start
);

    typedef enum logic [1:0] {
        COIN_IDLE,
        COIN_PULSE,
        COIN_LOCKOUT
    } coin_state_t;

    // DIP bytes survive core reset: the HPS only resends them on a fresh download.
    logic [8*NUM_DSW-1:0] dsw_q       = '1;
    logic                 dsw_valid_q = 1'b0;
    logic                 dsw_we;
    logic                 mask;
    logic                 vb_q;
    logic                 vb_rise;
    logic                 unused_bits;

    assign dsw_we      = ioctl_wr && (ioctl_index == DSW_INDEX) && (ioctl_addr < 27'(NUM_DSW));
    assign mask        = reset || ioctl_download;
    assign vb_rise     = vblank && !vb_q;
    assign unused_bits = ^{ioctl_dout[15:8], joy};
    assign dsw         = dsw_q;
    assign dsw_valid   = dsw_valid_q;

    always_ff @(posedge clk_sys) begin
        for (int n = 0; n < NUM_DSW; n++) begin
            if (dsw_we && ioctl_addr == 27'(n)) begin
                dsw_q[8*n +: 8] <= ioctl_dout[7:0];
            end
        end
        if (dsw_we) begin
            dsw_valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            vb_q <= 1'b0;
        end else begin
            vb_q <= vblank;
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [15:0] j;
        logic [7:0]  player_q;
        logic        start_q;
        logic        coin_q;
        logic        coin_s;
        logic        coin_d;
        logic        coin_rise;
        logic [3:0]  cnt;
        coin_state_t state;

        assign j                 = joy[16*p +: 16];
        assign coin_rise         = coin_s && !coin_d;
        assign player[8*p +: 8]  = player_q;
        assign start[p]          = start_q;
        assign coin[p]           = coin_q;

        always_ff @(posedge clk_sys) begin
            if (mask) begin
                player_q <= 8'hFF;
                start_q  <= 1'b0;
            end else begin
                player_q <= {2'b11, ~j[4], ~j[5], ~j[0], ~j[1], ~j[2], ~j[3]};
                start_q  <= j[START_BIT];
            end
        end

        // Edge history resets high so a button held across reset never counts as a press.
        always_ff @(posedge clk_sys) begin
            if (reset) begin
                coin_s <= 1'b1;
                coin_d <= 1'b1;
            end else begin
                coin_s <= j[COIN_BIT];
                coin_d <= coin_s;
            end
        end

        always_ff @(posedge clk_sys) begin
            if (mask) begin
                state  <= COIN_IDLE;
                cnt    <= COIN_FRAMES;
                coin_q <= 1'b0;
            end else begin
                case (state)
                    COIN_IDLE: begin
                        if (coin_rise) begin
                            state  <= COIN_PULSE;
                            cnt    <= COIN_FRAMES;
                            coin_q <= 1'b1;
                        end
                    end
                    COIN_PULSE: begin
                        if (vb_rise) begin
                            if (cnt == 4'd1) begin
                                state  <= COIN_LOCKOUT;
                                cnt    <= COIN_FRAMES;
                                coin_q <= 1'b0;
                            end else begin
                                cnt <= cnt - 4'd1;
                            end
                        end
                    end
                    COIN_LOCKOUT: begin
                        if (vb_rise) begin
                            if (cnt == 4'd1) begin
                                state <= COIN_IDLE;
                            end else begin
                                cnt <= cnt - 4'd1;
                            end
                        end
                    end
                    default: begin
                        state  <= COIN_IDLE;
                        coin_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_arcade_input_dsw.sv
// tb/tb_arcade_input_dsw.sv - self-checking bench for arcade_input_dsw against a frame-counting reference model
module tb_arcade_input_dsw;

    localparam int NP     = 2;
    localparam int ND     = 8;
    localparam int FRAMES = 3;

    logic          clk_sys;
    logic          reset;
    logic          ioctl_download;
    logic          ioctl_wr;
    logic [7:0]    ioctl_index;
    logic [26:0]   ioctl_addr;
    logic [15:0]   ioctl_dout;
    logic          vblank;
    logic [31:0]   joy;
    logic [63:0]   dsw;
    logic          dsw_valid;
    logic [15:0]   player;
    logic [1:0]    coin;
    logic [1:0]    start;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [7:0]  m_dsw [ND];
    logic        m_valid;
    int          m_pulse [NP];
    int          m_lock [NP];
    logic        m_s1 [NP];
    logic        m_s2 [NP];
    logic        m_vb;
    logic [15:0] m_player;
    logic [1:0]  m_start;
    logic [1:0]  m_coin;

    int model_err;
    int pulses [NP];
    int rises_hi [NP];

    arcade_input_dsw dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .vblank         (vblank),
        .joy            (joy),
        .dsw            (dsw),
        .dsw_valid      (dsw_valid),
        .player         (player),
        .coin           (coin),
        .start          (start)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    function automatic logic [63:0] m_dsw_packed();
        logic [63:0] r;
        for (int n = 0; n < ND; n++) r[8*n +: 8] = m_dsw[n];
        return r;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic        vbr;
        logic        rise;
        logic [15:0] j;
        vbr = vblank && !m_vb;
        if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr < 27'd8) begin
            m_dsw[ioctl_addr[2:0]] = ioctl_dout[7:0];
            m_valid = 1'b1;
        end
        for (int p = 0; p < NP; p++) begin
            j = joy[16*p +: 16];
            rise = m_s1[p] && !m_s2[p];
            if (reset || ioctl_download) begin
                m_player[8*p +: 8] = 8'hFF;
                m_start[p] = 1'b0;
                m_pulse[p] = 0;
                m_lock[p]  = 0;
            end else begin
                m_player[8*p +: 8] = {1'b1, 1'b1, !j[4], !j[5], !j[0], !j[1], !j[2], !j[3]};
                m_start[p] = j[9];
                if (m_pulse[p] > 0) begin
                    if (vbr) begin
                        m_pulse[p] = m_pulse[p] - 1;
                        if (m_pulse[p] == 0) m_lock[p] = FRAMES;
                    end
                end else if (m_lock[p] > 0) begin
                    if (vbr) m_lock[p] = m_lock[p] - 1;
                end else if (rise) begin
                    m_pulse[p] = FRAMES;
                end
            end
            m_coin[p] = (m_pulse[p] > 0);
            m_s2[p] = reset ? 1'b1 : m_s1[p];
            m_s1[p] = reset ? 1'b1 : j[8];
        end
        m_vb = reset ? 1'b0 : vblank;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_sys);
        #1;
    endtask

    // One video frame: 4 active lines then 2 blanking lines; records coin activity.
    task automatic frame();
        logic [1:0] prev;
        for (int i = 0; i < 6; i++) begin
            vblank = (i >= 4);
            if (i == 4) begin
                for (int p = 0; p < NP; p++) if (coin[p]) rises_hi[p]++;
            end
            prev = coin;
            tick();
            for (int p = 0; p < NP; p++) if (coin[p] && !prev[p]) pulses[p]++;
            if (coin !== m_coin) model_err++;
        end
    endtask

    task automatic clear_stats();
        model_err = 0;
        for (int p = 0; p < NP; p++) begin
            pulses[p]   = 0;
            rises_hi[p] = 0;
        end
    endtask

    task automatic quiet_reset();
        joy = '0;
        vblank = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        clear_stats();
    endtask

    task automatic dsw_write(input logic [7:0] idx, input logic [26:0] addr, input logic [7:0] data);
        ioctl_index = idx;
        ioctl_addr  = addr;
        ioctl_dout  = {8'($urandom_range(0, 255)), data};
        ioctl_wr    = 1'b1;
        tick();
        ioctl_wr    = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (dsw !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL powerup_dsw got=%h want=ffffffffffffffff", dsw); end
        total++; if (dsw_valid !== 1'b0) begin bad++; $display("FAIL powerup_valid got=%b want=0", dsw_valid); end
        reset = 1'b1;
        tick();
        tick();
        total++; if (player !== 16'hFFFF) begin bad++; $display("FAIL reset_player got=%h want=ffff", player); end
        total++; if (start !== 2'b00) begin bad++; $display("FAIL reset_start got=%b want=00", start); end
        total++; if (coin !== 2'b00) begin bad++; $display("FAIL reset_coin got=%b want=00", coin); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_dsw();
        ioctl_download = 1'b1;
        dsw_write(8'd254, 27'd0, 8'h12);
        dsw_write(8'd254, 27'd1, 8'h34);
        dsw_write(8'd254, 27'd2, 8'h56);
        total++; if (dsw[23:0] !== 24'h563412) begin bad++; $display("FAIL dsw_low got=%h want=563412", dsw[23:0]); end
        total++; if (dsw[63:24] !== 40'hFF_FFFF_FFFF) begin bad++; $display("FAIL dsw_high got=%h want=ffffffffff", dsw[63:24]); end
        total++; if (dsw_valid !== 1'b1) begin bad++; $display("FAIL dsw_valid got=%b want=1", dsw_valid); end
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        total++; if (dsw !== 64'hFFFF_FFFF_FF56_3412) begin bad++; $display("FAIL dsw_after_reset got=%h want=ffffffffff563412", dsw); end
        total++; if (dsw_valid !== 1'b1) begin bad++; $display("FAIL valid_after_reset got=%b want=1", dsw_valid); end
        dsw_write(8'd0, 27'd3, 8'h77);
        dsw_write(8'd254, 27'd9, 8'h88);
        dsw_write(8'd254, 27'd8, 8'h99);
        total++; if (dsw !== 64'hFFFF_FFFF_FF56_3412) begin bad++; $display("FAIL dsw_ignored got=%h want=ffffffffff563412", dsw); end
        dsw_write(8'd254, 27'd7, 8'hA5);
        total++; if (dsw[63:56] !== 8'hA5) begin bad++; $display("FAIL dsw_byte7 got=%h want=a5", dsw[63:56]); end
        for (int k = 0; k < 24; k++) begin
            dsw_write(($urandom_range(0, 1) == 1) ? 8'd254 : 8'($urandom_range(0, 253)),
                      27'($urandom_range(0, 11)), 8'($urandom_range(0, 255)));
            total++; if (dsw !== m_dsw_packed()) begin bad++; $display("FAIL dsw_random got=%h want=%h", dsw, m_dsw_packed()); end
        end
        ioctl_download = 1'b0;
        tick();
    endtask

    task automatic test_player();
        joy = 32'h0000_0011;
        tick();
        total++; if (player[7:0] !== 8'hD7) begin bad++; $display("FAIL player_d7 got=%h want=d7", player[7:0]); end
        total++; if (player[15:8] !== 8'hFF) begin bad++; $display("FAIL player1_idle got=%h want=ff", player[15:8]); end
        joy = 32'h0200_0000;
        tick();
        total++; if (start !== 2'b10) begin bad++; $display("FAIL start_p1 got=%b want=10", start); end
        ioctl_download = 1'b1;
        tick();
        total++; if (player !== 16'hFFFF) begin bad++; $display("FAIL dl_player got=%h want=ffff", player); end
        total++; if (start !== 2'b00) begin bad++; $display("FAIL dl_start got=%b want=00", start); end
        ioctl_download = 1'b0;
        for (int k = 0; k < 40; k++) begin
            joy = $urandom() & 32'hFEFF_FEFF;
            tick();
            total++; if (player !== m_player) begin bad++; $display("FAIL player_random got=%h want=%h joy=%h", player, m_player, joy); end
            total++; if (start !== m_start) begin bad++; $display("FAIL start_random got=%b want=%b", start, m_start); end
        end
        quiet_reset();
    endtask

    task automatic test_coin_hold();
        quiet_reset();
        joy = 32'h0000_0100;
        for (int f = 0; f < 10; f++) frame();
        total++; if (pulses[0] !== 1) begin bad++; $display("FAIL hold_pulses got=%0d want=1", pulses[0]); end
        total++; if (rises_hi[0] !== FRAMES) begin bad++; $display("FAIL hold_length got=%0d want=%0d", rises_hi[0], FRAMES); end
        total++; if (coin !== 2'b00) begin bad++; $display("FAIL hold_end got=%b want=00", coin); end
        joy = '0;
        frame();
        clear_stats();
        joy = 32'h0000_0100; frame();
        joy = '0; frame(); frame();
        frame();
        joy = 32'h0000_0100; frame();
        joy = '0; frame();
        total++; if (pulses[0] !== 1) begin bad++; $display("FAIL lockout_drop got=%0d want=1", pulses[0]); end
        frame();
        joy = 32'h0000_0100; frame();
        joy = '0; frame(); frame(); frame();
        total++; if (pulses[0] !== 2) begin bad++; $display("FAIL after_lockout got=%0d want=2", pulses[0]); end
        total++; if (model_err !== 0) begin bad++; $display("FAIL hold_model got=%0d errors want=0", model_err); end
    endtask

    task automatic test_coin_coincident();
        quiet_reset();
        joy = 32'h0100_0100;
        tick();
        vblank = 1'b1;
        tick();
        total++; if (coin !== 2'b11) begin bad++; $display("FAIL coinc_start got=%b want=11", coin); end
        tick();
        clear_stats();
        for (int f = 0; f < 4; f++) frame();
        total++; if (rises_hi[0] !== FRAMES) begin bad++; $display("FAIL coinc_len0 got=%0d want=%0d", rises_hi[0], FRAMES); end
        total++; if (rises_hi[1] !== FRAMES) begin bad++; $display("FAIL coinc_len1 got=%0d want=%0d", rises_hi[1], FRAMES); end
        total++; if (coin !== 2'b00) begin bad++; $display("FAIL coinc_end got=%b want=00", coin); end
        total++; if (pulses[0] + pulses[1] !== 0) begin bad++; $display("FAIL coinc_retrigger got=%0d want=0", pulses[0] + pulses[1]); end
        total++; if (model_err !== 0) begin bad++; $display("FAIL coinc_model got=%0d errors want=0", model_err); end
        joy = '0;
        for (int f = 0; f < 4; f++) frame();
    endtask

    task automatic test_coin_reset();
        quiet_reset();
        joy = 32'h0000_0100;
        frame();
        total++; if (coin[0] !== 1'b1) begin bad++; $display("FAIL midpulse got=%b want=1", coin[0]); end
        reset = 1'b1;
        tick();
        total++; if (coin !== 2'b00) begin bad++; $display("FAIL reset_midpulse got=%b want=00", coin); end
        reset = 1'b0;
        clear_stats();
        for (int f = 0; f < 5; f++) frame();
        total++; if (pulses[0] !== 0) begin bad++; $display("FAIL held_through_reset got=%0d want=0", pulses[0]); end
        joy = '0; frame();
        joy = 32'h0000_0100; frame();
        total++; if (pulses[0] !== 1) begin bad++; $display("FAIL repress got=%0d want=1", pulses[0]); end
        total++; if (coin[0] !== 1'b1) begin bad++; $display("FAIL repress_level got=%b want=1", coin[0]); end
        joy = '0;
        for (int f = 0; f < 6; f++) frame();
        total++; if (model_err !== 0) begin bad++; $display("FAIL reset_model got=%0d errors want=0", model_err); end
    endtask

    task automatic test_random();
        logic [1:0] cb;
        quiet_reset();
        cb = 2'b00;
        for (int k = 0; k < 2000; k++) begin
            for (int p = 0; p < NP; p++) if ($urandom_range(0, 15) == 0) cb[p] = ~cb[p];
            joy = ($urandom() & 32'hFEFF_FEFF) | {7'd0, cb[1], 15'd0, cb[0], 8'd0};
            if ($urandom_range(0, 5) == 0) vblank = ~vblank;
            if ($urandom_range(0, 199) == 0) ioctl_download = ~ioctl_download;
            reset = ($urandom_range(0, 299) == 0);
            tick();
            total++; if (player !== m_player) begin bad++; $display("FAIL rnd_player got=%h want=%h", player, m_player); end
            total++; if (start !== m_start) begin bad++; $display("FAIL rnd_start got=%b want=%b", start, m_start); end
            total++; if (coin !== m_coin) begin bad++; $display("FAIL rnd_coin got=%b want=%b cycle=%0d", coin, m_coin, k); end
        end
        total++; if (dsw !== m_dsw_packed()) begin bad++; $display("FAIL rnd_dsw got=%h want=%h", dsw, m_dsw_packed()); end
        total++; if (dsw_valid !== m_valid) begin bad++; $display("FAIL rnd_valid got=%b want=%b", dsw_valid, m_valid); end
        reset = 1'b0;
        ioctl_download = 1'b0;
        joy = '0;
    endtask

    initial begin
        reset = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_index = '0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        vblank = 1'b0;
        joy = '0;
        for (int n = 0; n < ND; n++) m_dsw[n] = 8'hFF;
        m_valid = 1'b0;
        m_vb = 1'b0;
        m_player = 16'hFFFF;
        m_start = '0;
        m_coin = '0;
        for (int p = 0; p < NP; p++) begin
            m_pulse[p] = 0;
            m_lock[p] = 0;
            m_s1[p] = 1'b1;
            m_s2[p] = 1'b1;
        end
        clear_stats();
        #1;
        test_reset();
        test_dsw();
        test_player();
        test_coin_hold();
        test_coin_coincident();
        test_coin_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
